// File: rtl/key_enc_pkg.sv
// rtl/key_enc_pkg.sv - shared constants, FSM encoding and priority pick for the key/encoder path
package key_enc_pkg;

  localparam int N_KEYS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [N_KEYS-1:0] ONEHOT_IDLE = 4'b0000;

  // Highest set index wins; returns a one-hot mask, or zero when nothing is requested.
  function automatic logic [N_KEYS-1:0] pick_highest(input logic [N_KEYS-1:0] req);
    logic [N_KEYS-1:0] sel;
    sel = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (req[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchroniser and counter debounce for one key, emits a one-cycle rise pulse
module key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differs, at_limit;

  assign differs  = (sync2_q != level_q);
  assign at_limit = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (differs) begin
      if (at_limit) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Pulses on the same edge the debounced level goes 0->1.
  assign rise_o = differs && at_limit && sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/key_onehot_capture.sv
// rtl/key_onehot_capture.sv - debounced key presses to held one-hot codes with ack handshake
// Optional sticky overflow output when KEY_OVERFLOW_FLAG_EN is defined.
module key_onehot_capture
  import key_enc_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] onehot_out,
  output logic              onehot_valid,
`ifdef KEY_OVERFLOW_FLAG_EN
  output logic              overflow,
`endif
  input  logic              onehot_ack
);

  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] grant, clr;
  logic [N_KEYS-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  state_e            state_q, state_d;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .key_i (key_in[k]),
      .rise_o(rise[k])
    );
  end

  assign grant = pick_highest(pending_q);

  // A press landing on the same edge its bit is served stays pending.
  assign pending_d = (pending_q & ~clr) | rise;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending_q) state_d = HOLD;
      HOLD:    if (onehot_ack) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          out_d   = grant;
          valid_d = 1'b1;
          clr     = grant;
        end else begin
          out_d   = ONEHOT_IDLE;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (onehot_ack) begin
          out_d   = ONEHOT_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        out_d   = ONEHOT_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      out_q     <= ONEHOT_IDLE;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
    end
  end

  assign onehot_out   = out_q;
  assign onehot_valid = valid_q;

`ifdef KEY_OVERFLOW_FLAG_EN
  logic overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (|(rise & pending_q & ~clr)) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule
